// File: rtl/fifo_ctrl_if.sv
// Handshake and SRAM-side signal bundle for fifo_ctrl.
// The slave modport is the controller; the master modport is its client and SRAM.
interface fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 8
);
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [BUS_WIDTH:0]    count;
  logic                  overflow;
  logic                  underflow;
  logic                  sram_cs;
  logic                  sram_rd_en;
  logic                  sram_wr_en;
  logic [BUS_WIDTH-1:0]  sram_read_addr;
  logic [BUS_WIDTH-1:0]  sram_write_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  modport slave (
    input  push, push_data, pop, sram_dout,
    output pop_data, pop_valid, full, empty, almost_full, count,
           overflow, underflow, sram_cs, sram_rd_en, sram_wr_en,
           sram_read_addr, sram_write_addr, sram_din
  );

  modport master (
    output push, push_data, pop, sram_dout,
    input  pop_data, pop_valid, full, empty, almost_full, count,
           overflow, underflow, sram_cs, sram_rd_en, sram_wr_en,
           sram_read_addr, sram_write_addr, sram_din
  );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO controller around an external single-cycle-latency SRAM.
// Pointers carry a wrap bit so full and empty are distinguished without extra state.
module fifo_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 8,
  parameter int AFULL_LEVEL = 2**BUS_WIDTH - 2
) (
  input logic       clk,
  input logic       rst_n,
  fifo_ctrl_if.slave bus
);

  localparam logic [BUS_WIDTH:0] AFULL_THR = (BUS_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [BUS_WIDTH:0] ONE       = (BUS_WIDTH+1)'(1);

  logic [BUS_WIDTH:0] wptr;
  logic [BUS_WIDTH:0] rptr;
  logic [BUS_WIDTH:0] count_q;
  logic               pop_valid_q;
  logic               almost_full_q;
  logic               overflow_q;
  logic               underflow_q;
  logic               full_w;
  logic               empty_w;
  logic               push_acc;
  logic               pop_acc;

  // Acceptance is gated by reset so no SRAM strobe escapes while rst_n is low.
  assign empty_w  = (wptr == rptr);
  assign full_w   = (wptr[BUS_WIDTH-1:0] == rptr[BUS_WIDTH-1:0]) &&
                    (wptr[BUS_WIDTH] != rptr[BUS_WIDTH]);
  assign push_acc = rst_n & bus.push & ~full_w;
  assign pop_acc  = rst_n & bus.pop  & ~empty_w;

  assign bus.sram_wr_en      = push_acc;
  assign bus.sram_rd_en      = pop_acc;
  assign bus.sram_cs         = push_acc | pop_acc;
  assign bus.sram_din        = bus.push_data;
  assign bus.sram_write_addr = wptr[BUS_WIDTH-1:0];
  assign bus.sram_read_addr  = rptr[BUS_WIDTH-1:0];

  assign bus.pop_data    = bus.sram_dout;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.count       = count_q;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

  // almost_full samples the pre-edge count, so it trails count by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr          <= '0;
      rptr          <= '0;
      count_q       <= '0;
      pop_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      if (push_acc) begin
        wptr <= wptr + ONE;
      end
      if (pop_acc) begin
        rptr <= rptr + ONE;
      end
      if (push_acc && !pop_acc) begin
        count_q <= count_q + ONE;
      end else if (pop_acc && !push_acc) begin
        count_q <= count_q - ONE;
      end
      pop_valid_q   <= pop_acc;
      almost_full_q <= (count_q >= AFULL_THR);
      overflow_q    <= bus.push & ~push_acc;
      underflow_q   <= bus.pop  & ~pop_acc;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a queue-based reference predicts every output,
// and a monitor checks each pop_valid beat against expected data in order.
module tb_fifo_ctrl;

  localparam int DW    = 8;
  localparam int BW    = 3;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic clk;
  logic rst_n;

  fifo_ctrl_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) bus ();

  fifo_ctrl #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .AFULL_LEVEL(AFULL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic [DW-1:0] mem [DEPTH];

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];
  int            wcnt;
  int            rcnt;
  logic          ovf_exp;
  logic          unf_exp;
  logic          afull_exp;
  logic          pv_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM behaviour: synchronous write, registered read.
  always @(posedge clk) begin
    if (bus.sram_cs && bus.sram_wr_en) mem[bus.sram_write_addr] <= bus.sram_din;
    if (bus.sram_cs && bus.sram_rd_en) bus.sram_dout <= mem[bus.sram_read_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every beat presented must be the oldest outstanding expected word.
  always @(posedge clk) begin
    #1;
    if (bus.pop_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL pop_data: got 0x%0h with no word expected at %0t", bus.pop_data, $time);
      end else begin
        check("pop_data", 32'(bus.pop_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_output(input logic p, input logic [DW-1:0] d, input logic q);
    logic m_full;
    logic m_empty;
    logic pa;
    logic qa;
    m_full  = (model_q.size() == DEPTH);
    m_empty = (model_q.size() == 0);
    pa = p && !m_full;
    qa = q && !m_empty;
    check("sram_wr_en", 32'(bus.sram_wr_en), 32'(pa));
    check("sram_rd_en", 32'(bus.sram_rd_en), 32'(qa));
    check("sram_cs", 32'(bus.sram_cs), 32'(pa || qa));
    if (pa) begin
      check("sram_write_addr", 32'(bus.sram_write_addr), 32'(wcnt % DEPTH));
      check("sram_din", 32'(bus.sram_din), 32'(d));
    end
    if (qa) check("sram_read_addr", 32'(bus.sram_read_addr), 32'(rcnt % DEPTH));
    check("full", 32'(bus.full), 32'(m_full));
    check("empty", 32'(bus.empty), 32'(m_empty));
    check("count", 32'(bus.count), 32'(model_q.size()));
    check("overflow", 32'(bus.overflow), 32'(ovf_exp));
    check("underflow", 32'(bus.underflow), 32'(unf_exp));
    check("almost_full", 32'(bus.almost_full), 32'(afull_exp));
    check("pop_valid", 32'(bus.pop_valid), 32'(pv_exp));
    // Advance the reference as the coming clock edge will.
    ovf_exp   = p && !pa;
    unf_exp   = q && !qa;
    afull_exp = (model_q.size() >= AFULL);
    pv_exp    = qa;
    if (qa) begin
      exp_q.push_back(model_q.pop_front());
      rcnt++;
    end
    if (pa) begin
      model_q.push_back(d);
      wcnt++;
    end
  endtask

  task automatic apply_stimulus(input logic p, input logic [DW-1:0] d, input logic q);
    @(negedge clk);
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = q;
    #1;
    check_output(p, d, q);
  endtask

  // Reset with both requests held high: nothing may be accepted or reported.
  task automatic do_reset();
    @(negedge clk);
    bus.push      = 1'b1;
    bus.pop       = 1'b1;
    bus.push_data = 8'hEE;
    rst_n         = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    check("rst_almost_full", 32'(bus.almost_full), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
    check("rst_sram_cs", 32'(bus.sram_cs), 32'd0);
    check("rst_sram_wr_en", 32'(bus.sram_wr_en), 32'd0);
    check("rst_sram_rd_en", 32'(bus.sram_rd_en), 32'd0);
    model_q.delete();
    exp_q.delete();
    wcnt = 0; rcnt = 0;
    ovf_exp = 1'b0; unf_exp = 1'b0; afull_exp = 1'b0; pv_exp = 1'b0;
    repeat (2) @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = '0;
    do_reset();

    apply_stimulus(1'b1, 8'h11, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);

    for (int i = 1; i <= 8; i++) apply_stimulus(1'b1, 8'(i), 1'b0);
    apply_stimulus(1'b1, 8'h09, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 8'h0A, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0);

    apply_stimulus(1'b1, 8'hAA, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 22; i++) apply_stimulus(i < 20, 8'(8'h30 + i), i >= 2);
    apply_stimulus(1'b0, 8'h00, 1'b1);

    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 120; i++) begin
        int bias;
        bias = (phase == 0) ? 75 : (phase == 1) ? 25 : 50;
        apply_stimulus($urandom_range(0, 99) < bias, 8'($urandom),
                       $urandom_range(0, 99) < (100 - bias));
      end
    end
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'(8'hC0 + i), 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    do_reset();
    apply_stimulus(1'b1, 8'h5A, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);

    check("outstanding_words", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
